// File: rtl/dmem_arbiter.sv
// dmem_arbiter: single-port data-memory arbiter between the load unit and the
// store queue. One access in flight at a time; loads have priority.
// Optional feature macro: ARB_STARVE_EN (bounded store starvation via a
// 3-bit counter of load grants issued while a store waits).
module dmem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flsh,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_grnt,
  output logic              ld_done,
  output logic [DATA_W-1:0] ld_data,
  input  logic              str_req,
  input  logic [ADDR_W-1:0] str_addr,
  input  logic [DATA_W-1:0] str_data,
  output logic              str_grnt,
  output logic              done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_LD_BUSY = 2'b01,
    ST_ST_BUSY = 2'b10
  } state_t;

  state_t            r_state;
  logic              r_ld_grnt;
  logic              r_ld_done;
  logic [DATA_W-1:0] r_ld_data;
  logic              r_str_grnt;
  logic              r_done;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_squash;

  logic              w_ld_ok;
  logic              w_pick_st;
  logic              w_pick_ld;

`ifdef ARB_STARVE_EN
  localparam logic [2:0] LP_STARVE_MAX = 3'(STARVE_MAX);
  logic [2:0]        r_starve_cnt;
  logic              w_starved;
`endif

  // Arbitration decision for the IDLE state: a flush masks the load request.
  always_comb begin
    w_ld_ok   = ld_req & ~flsh;
`ifdef ARB_STARVE_EN
    w_starved = (r_starve_cnt == LP_STARVE_MAX);
    w_pick_st = str_req & (~w_ld_ok | w_starved);
`else
    w_pick_st = str_req & ~w_ld_ok;
`endif
    w_pick_ld = w_ld_ok & ~w_pick_st;
  end

  // Main FSM: grants, memory port drive, completion pulses and load data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ld_grnt   <= 1'b0;
      r_ld_done   <= 1'b0;
      r_ld_data   <= '0;
      r_str_grnt  <= 1'b0;
      r_done      <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_squash    <= 1'b0;
    end else begin
      r_ld_grnt  <= 1'b0;
      r_ld_done  <= 1'b0;
      r_str_grnt <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_st) begin
            r_state     <= ST_ST_BUSY;
            r_str_grnt  <= 1'b1;
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= str_addr;
            r_mem_wdata <= str_data;
          end else if (w_pick_ld) begin
            r_state    <= ST_LD_BUSY;
            r_ld_grnt  <= 1'b1;
            r_mem_en   <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= ld_addr;
            r_squash   <= 1'b0;
          end
        end
        ST_LD_BUSY: begin
          if (mem_rdy) begin
            r_state  <= ST_IDLE;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            // A flush anywhere from grant to completion discards the result.
            if (!(r_squash || flsh)) begin
              r_ld_data <= mem_rdata;
              r_ld_done <= 1'b1;
            end
          end else if (flsh) begin
            r_squash <= 1'b1;
          end
        end
        ST_ST_BUSY: begin
          if (mem_rdy) begin
            r_state  <= ST_IDLE;
            r_done   <= 1'b1;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_STARVE_EN
  // Starvation counter: counts load grants taken while a store was waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= 3'd0;
    end else if ((r_state == ST_IDLE) && w_pick_st) begin
      r_starve_cnt <= 3'd0;
    end else if ((r_state == ST_IDLE) && w_pick_ld && str_req && (r_starve_cnt != 3'd7)) begin
      r_starve_cnt <= r_starve_cnt + 3'd1;
    end
  end
`endif

  assign ld_grnt   = r_ld_grnt;
  assign ld_done   = r_ld_done;
  assign ld_data   = r_ld_data;
  assign str_grnt  = r_str_grnt;
  assign done      = r_done;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed vector table, a held-request
// starvation sequence and a randomized run against a reference model.
module tb_dmem_arbiter;

`ifdef ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst, flsh, ld_req, str_req, mem_rdy;
  logic [15:0] ld_addr, str_addr, str_data, mem_rdata;
  logic        ld_grnt, ld_done, str_grnt, done, mem_en, mem_we;
  logic [15:0] ld_data, mem_addr, mem_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst), .flsh(flsh),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_grnt(ld_grnt), .ld_done(ld_done), .ld_data(ld_data),
    .str_req(str_req), .str_addr(str_addr), .str_data(str_data), .str_grnt(str_grnt), .done(done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rst; logic flsh; logic lr; logic [15:0] la; logic sr; logic [15:0] sa; logic [15:0] sd;
    logic [15:0] rd; logic rdy;
    logic e_lg; logic e_ldn; logic [15:0] e_ldd; logic e_sg; logic e_dn; logic e_en; logic e_we;
    logic [15:0] e_addr; logic [15:0] e_wd;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [53:0] dut_pack();
    return {ld_grnt, ld_done, ld_data, str_grnt, done, mem_en, mem_we, mem_addr, mem_wdata};
  endfunction

  task automatic check(input string name, input int idx, input logic [53:0] act, input logic [53:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s #%0d: got %h, expected %h", name, idx, act, req);
    end
  endtask

  // Reference model: abstract "which access is outstanding" bookkeeping.
  int          m_kind;   // 0: nothing outstanding, 1: load, 2: store
  bit          m_squash;
  int          m_starve;
  logic        x_lg, x_ldn, x_sg, x_dn, x_en, x_we;
  logic [15:0] x_ldd, x_addr, x_wd;

  task automatic model_edge();
    bit ld_ok, take_st;
    x_lg = 1'b0; x_ldn = 1'b0; x_sg = 1'b0; x_dn = 1'b0;
    if (rst) begin
      m_kind = 0; m_squash = 1'b0; m_starve = 0;
      x_en = 1'b0; x_we = 1'b0; x_ldd = 16'h0000; x_addr = 16'h0000; x_wd = 16'h0000;
      return;
    end
    if (m_kind == 0) begin
      ld_ok   = ld_req && !flsh;
      take_st = str_req && (!ld_ok || (STARVE_EN && m_starve == STARVE_MAX));
      if (take_st) begin
        m_kind = 2; x_sg = 1'b1; x_en = 1'b1; x_we = 1'b1;
        x_addr = str_addr; x_wd = str_data; m_starve = 0;
      end else if (ld_ok) begin
        m_kind = 1; m_squash = 1'b0; x_lg = 1'b1; x_en = 1'b1; x_we = 1'b0;
        x_addr = ld_addr;
        if (str_req) m_starve++;
      end
    end else begin
      if (m_kind == 1 && flsh) m_squash = 1'b1;
      if (mem_rdy) begin
        if (m_kind == 1 && !m_squash) begin
          x_ldn = 1'b1; x_ldd = mem_rdata;
        end
        if (m_kind == 2) x_dn = 1'b1;
        m_kind = 0; x_en = 1'b0; x_we = 1'b0;
      end
    end
  endtask

  int  n_lg, n_sg;
  bit  ld_pend, st_pend;

  initial begin
    rst = 1'b1; flsh = 1'b0; ld_req = 1'b0; str_req = 1'b0; mem_rdy = 1'b0;
    ld_addr = 16'h0000; str_addr = 16'h0000; str_data = 16'h0000; mem_rdata = 16'h0000;

    //          rst   flsh  lr    la        sr    sa        sd        rd        rdy   lg    ldn   ldd       sg    dn    en    we    addr      wd
    tbl.push_back('{1'b1,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000,16'h0000,1'b0, 1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000}); // reset
    tbl.push_back('{1'b0,1'b0,1'b0,16'h0000,1'b1,16'hAAAA,16'hFFFF,16'h0000,1'b1, 1'b0,1'b0,16'h0000,1'b1,1'b0,1'b1,1'b1,16'hAAAA,16'hFFFF}); // store grant
    tbl.push_back('{1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000,16'h0000,1'b1, 1'b0,1'b0,16'h0000,1'b0,1'b1,1'b0,1'b0,16'hAAAA,16'hFFFF}); // done
    tbl.push_back('{1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000,16'h0000,1'b1, 1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0,16'hAAAA,16'hFFFF}); // idle rdy ignored
    tbl.push_back('{1'b0,1'b0,1'b1,16'hBBBB,1'b0,16'h0000,16'h0000,16'h0000,1'b0, 1'b1,1'b0,16'h0000,1'b0,1'b0,1'b1,1'b0,16'hBBBB,16'hFFFF}); // load grant
    tbl.push_back('{1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000,16'h0000,1'b0, 1'b0,1'b0,16'h0000,1'b0,1'b0,1'b1,1'b0,16'hBBBB,16'hFFFF});
    tbl.push_back('{1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000,16'h0000,1'b0, 1'b0,1'b0,16'h0000,1'b0,1'b0,1'b1,1'b0,16'hBBBB,16'hFFFF});
    tbl.push_back('{1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000,16'h1111,1'b1, 1'b0,1'b1,16'h1111,1'b0,1'b0,1'b0,1'b0,16'hBBBB,16'hFFFF}); // ld_done
    tbl.push_back('{1'b0,1'b0,1'b1,16'h1234,1'b1,16'h5678,16'h9ABC,16'h2222,1'b1, 1'b1,1'b0,16'h1111,1'b0,1'b0,1'b1,1'b0,16'h1234,16'hFFFF}); // both: load wins
    tbl.push_back('{1'b0,1'b0,1'b0,16'h0000,1'b1,16'h5678,16'h9ABC,16'h2222,1'b1, 1'b0,1'b1,16'h2222,1'b0,1'b0,1'b0,1'b0,16'h1234,16'hFFFF}); // ld_done, no grant
    tbl.push_back('{1'b0,1'b0,1'b0,16'h0000,1'b1,16'h5678,16'h9ABC,16'h0000,1'b0, 1'b0,1'b0,16'h2222,1'b1,1'b0,1'b1,1'b1,16'h5678,16'h9ABC}); // store grant
    tbl.push_back('{1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000,16'h0000,1'b1, 1'b0,1'b0,16'h2222,1'b0,1'b1,1'b0,1'b0,16'h5678,16'h9ABC});
    tbl.push_back('{1'b0,1'b0,1'b1,16'h4444,1'b0,16'h0000,16'h0000,16'h3333,1'b0, 1'b1,1'b0,16'h2222,1'b0,1'b0,1'b1,1'b0,16'h4444,16'h9ABC}); // load for flush
    tbl.push_back('{1'b0,1'b1,1'b0,16'h0000,1'b0,16'h0000,16'h0000,16'h3333,1'b0, 1'b0,1'b0,16'h2222,1'b0,1'b0,1'b1,1'b0,16'h4444,16'h9ABC}); // flush
    tbl.push_back('{1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000,16'h3333,1'b0, 1'b0,1'b0,16'h2222,1'b0,1'b0,1'b1,1'b0,16'h4444,16'h9ABC});
    tbl.push_back('{1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000,16'h3333,1'b1, 1'b0,1'b0,16'h2222,1'b0,1'b0,1'b0,1'b0,16'h4444,16'h9ABC}); // squashed
    tbl.push_back('{1'b0,1'b0,1'b0,16'h0000,1'b1,16'h0F0F,16'h00AA,16'h0000,1'b1, 1'b0,1'b0,16'h2222,1'b1,1'b0,1'b1,1'b1,16'h0F0F,16'h00AA});
    tbl.push_back('{1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000,16'h0000,1'b1, 1'b0,1'b0,16'h2222,1'b0,1'b1,1'b0,1'b0,16'h0F0F,16'h00AA});
    tbl.push_back('{1'b0,1'b1,1'b1,16'h7777,1'b0,16'h0000,16'h0000,16'h0000,1'b0, 1'b0,1'b0,16'h2222,1'b0,1'b0,1'b0,1'b0,16'h0F0F,16'h00AA}); // flush masks ld_req
    tbl.push_back('{1'b0,1'b0,1'b1,16'h7777,1'b0,16'h0000,16'h0000,16'h0000,1'b0, 1'b1,1'b0,16'h2222,1'b0,1'b0,1'b1,1'b0,16'h7777,16'h00AA});
    tbl.push_back('{1'b0,1'b1,1'b0,16'h0000,1'b0,16'h0000,16'h0000,16'h5555,1'b1, 1'b0,1'b0,16'h2222,1'b0,1'b0,1'b0,1'b0,16'h7777,16'h00AA}); // flush on rdy cycle
    tbl.push_back('{1'b0,1'b0,1'b0,16'h0000,1'b1,16'h1357,16'h2468,16'h0000,1'b0, 1'b0,1'b0,16'h2222,1'b1,1'b0,1'b1,1'b1,16'h1357,16'h2468});
    tbl.push_back('{1'b1,1'b0,1'b0,16'h0000,1'b1,16'h1357,16'h2468,16'h0000,1'b1, 1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000}); // rst in ST_BUSY
    tbl.push_back('{1'b0,1'b0,1'b0,16'h0000,1'b1,16'h1357,16'h2468,16'h0000,1'b1, 1'b0,1'b0,16'h0000,1'b1,1'b0,1'b1,1'b1,16'h1357,16'h2468}); // re-grant
    tbl.push_back('{1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000,16'h0000,1'b1, 1'b0,1'b0,16'h0000,1'b0,1'b1,1'b0,1'b0,16'h1357,16'h2468});

    // Directed vectors.
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; flsh = tbl[i].flsh; ld_req = tbl[i].lr; ld_addr = tbl[i].la;
      str_req = tbl[i].sr; str_addr = tbl[i].sa; str_data = tbl[i].sd;
      mem_rdata = tbl[i].rd; mem_rdy = tbl[i].rdy;
      @(posedge clk); #1;
      check("vector", i, dut_pack(),
            {tbl[i].e_lg, tbl[i].e_ldn, tbl[i].e_ldd, tbl[i].e_sg, tbl[i].e_dn,
             tbl[i].e_en, tbl[i].e_we, tbl[i].e_addr, tbl[i].e_wd});
    end

    // Held load and store requests with an always-ready memory.
    rst = 1'b1; flsh = 1'b0; ld_req = 1'b0; str_req = 1'b0; mem_rdy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; ld_req = 1'b1; ld_addr = 16'h00C0; str_req = 1'b1; str_addr = 16'h00D0;
    str_data = 16'hBEEF; mem_rdy = 1'b1; mem_rdata = 16'h0101;
    n_lg = 0; n_sg = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      n_lg += int'(ld_grnt);
      n_sg += int'(str_grnt);
    end
    check("held_ld_grants", 0, 54'(n_lg), STARVE_EN ? 54'd8 : 54'd10);
    check("held_st_grants", 0, 54'(n_sg), STARVE_EN ? 54'd2 : 54'd0);

    // Randomized traffic against the reference model.
    ld_pend = 1'b0; st_pend = 1'b0;
    for (int c = 0; c < 800; c++) begin
      rst = (c == 0) || ($urandom_range(0, 99) == 0);
      flsh = ($urandom_range(0, 7) == 0);
      mem_rdy = ($urandom_range(0, 2) != 0);
      mem_rdata = 16'($urandom);
      if (!ld_pend) begin
        ld_addr = 16'($urandom);
        ld_pend = ($urandom_range(0, 2) == 0);
      end
      if (!st_pend) begin
        str_addr = 16'($urandom);
        str_data = 16'($urandom);
        st_pend = ($urandom_range(0, 2) == 0);
      end
      ld_req = ld_pend;
      str_req = st_pend;
      model_edge();
      @(posedge clk); #1;
      check("random", c, dut_pack(), {x_lg, x_ldn, x_ldd, x_sg, x_dn, x_en, x_we, x_addr, x_wd});
      if (x_lg) ld_pend = 1'b0;
      if (x_sg) st_pend = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
